dbus_responder: RTL and testbench
=================================

// Module: dbus_responder
// PURPOSE
//   Target end of the data-bus protocol that the memory stage drives. Accepts one
//   dbus_req_t at a time, waits a programmable latency, then commits the write or
//   returns the read word on dbus_resp_t. Backed by an on-chip 64-bit-word array.
//   Serves as the simulation data memory and as the template for the cache slave port.
// PARAMETERS
//   MEM_WORDS  1024         number of 64-bit words; power of two
//   BASE_ADDR  64'h8000_0000 byte address of word 0; must be MEM_WORDS*8 aligned
//   LATENCY    2            clock edges from request acceptance to data_ok; range 1..15
// PORTS
//   clk     in   1    clock; all state updates on the rising edge
//   resetn  in   1    asynchronous, active-low reset
//   dreq    in   140  dbus_req_t {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}
//   dresp   out  66   dbus_resp_t {addr_ok, data_ok, data[63:0]}
//   oob     out  1    one-cycle pulse together with data_ok when the request was out of range
// BEHAVIOUR
//   Reset (resetn=0, async): state=IDLE; cnt=0; dresp='0; oob=0. Array contents are NOT
//     reset and persist across reset. Simulation initialises the array to zero at time 0.
//   Initiator rule: dreq is held stable while valid=1 until data_ok=1 is sampled.
//     The responder latches dreq on acceptance and ignores later changes.
//   FSM has three states; every dresp/oob bit is registered:
//   - IDLE: on an edge with dreq.valid=1, latch addr, strobe and data into req_q,
//     set cnt=LATENCY-1, and go to WAIT. addr_ok=1 for exactly the next cycle.
//     With valid=0, stay in IDLE and hold all outputs at 0.
//   - WAIT: on each edge, if cnt!=0 then cnt--. If cnt==0, go to RESP on that edge,
//     which also:
//       write (req_q.strobe!=0): byte i of the word is replaced by data[8i+7:8i]
//         for every strobe[i]=1. Other bytes are unchanged. dresp.data=0.
//       read (strobe==0): dresp.data = the full 64-bit word, with no byte shifting;
//         the initiator extracts the bytes it needs.
//     addr_ok=0 throughout WAIT.
//   - RESP: data_ok=1 for exactly one cycle. On the next edge go to IDLE and clear
//     data_ok, data and oob.
//   Timing: valid first sampled at edge E0 -> addr_ok high in cycle E0..E1 ->
//     data_ok high in cycle E(LATENCY)..E(LATENCY+1). Back-to-back requests issue no
//     earlier than 1 cycle after data_ok, because IDLE samples on the edge after RESP.
//   Indexing: idx = (addr - BASE_ADDR) >> 3, taking the low log2(MEM_WORDS) bits.
//     addr[2:0] and size are ignored; strobe alone selects bytes.
//   Out of range (addr < BASE_ADDR or addr >= BASE_ADDR + MEM_WORDS*8): the write is
//     dropped, read data is 64'h0, and oob=1 in the RESP cycle. The handshake is
//     otherwise identical.
//   Valid dropped mid-transaction (protocol violation): the latched request still
//     completes, the write still commits, and data_ok still pulses.
//   Reset asserted mid-transaction: return to IDLE immediately with outputs 0. A write
//     not yet committed (still in WAIT) is discarded. Committed bytes remain.
//   A read and a write never target the same cycle, since there is one outstanding
//     request, so no bypass is required.
// TESTING
//   1. resetn low for 3 cycles with dreq.valid=1 -> addr_ok=data_ok=0 and oob=0
//      throughout; first addr_ok occurs in the cycle after the first edge with resetn=1.
//   2. Write addr=0x8000_0010, strobe=8'hFF, data=64'h1122334455667788, then read the
//      same addr -> read data=64'h1122334455667788; with LATENCY=2, data_ok appears
//      2 edges after the accept edge and lasts 1 cycle.
//   3. Partial write strobe=8'h0F, data=64'hAAAA_BBBB_CCCC_DDDD to the word from test 2,
//      then read it -> 64'h11223344CCCCDDDD.
//   4. Read addr=0x7FFF_FFF8, and write to BASE_ADDR+MEM_WORDS*8 -> oob=1 with data_ok;
//      read data 0; array contents unchanged, checked by reading back word 0 and the
//      last word.
//   5. Ten back-to-back reads with valid held high -> exactly 10 addr_ok and 10 data_ok
//      pulses; LATENCY+2 cycles per transaction.
//   6. Write accepted, then resetn pulsed low during WAIT -> no data_ok; a following
//      read of that address returns the old value.

Source files
------------

// File: rtl/dbus_responder.sv
// dbus_responder: target end of the memory-stage data bus.
// Accepts one request at a time, waits LATENCY edges, then commits the write
// or returns the read word. The backing store is an array of 64-bit words.
// dreq  = {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}
// dresp = {addr_ok, data_ok, data[63:0]}
module dbus_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [139:0] dreq,
    output logic [65:0]  dresp,
    output logic         oob
);

    localparam int          IDX_W    = $clog2(MEM_WORDS);
    localparam logic [63:0] SPAN     = 64'(MEM_WORDS) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Expand the byte strobe into a 64-bit bit mask.
    function automatic logic [63:0] strobe_mask(input logic [7:0] strobe);
        logic [63:0] mask;
        mask = 64'd0;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

    // Request fields
    logic        req_valid_s;
    logic [63:0] req_addr_s;
    logic [7:0]  req_strobe_s;
    logic [63:0] req_data_s;

    assign req_valid_s  = dreq[139];
    assign req_addr_s   = dreq[138:75];
    assign req_strobe_s = dreq[71:64];
    assign req_data_s   = dreq[63:0];

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [63:0] addr_r, wdata_r;
    logic [7:0]  strobe_r;
    logic        addr_ok_r, addr_ok_s;
    logic        data_ok_r, data_ok_s;
    logic [63:0] rdata_r, rdata_s;
    logic        oob_r, oob_s;
    logic        latch_s;
    logic        commit_s;

    logic [63:0] mem_r [MEM_WORDS];

    // Address decode of the latched request
    logic [63:0]      offset_s;
    logic             in_range_s;
    logic [IDX_W-1:0] idx_s;

    assign offset_s   = addr_r - BASE_ADDR;
    assign in_range_s = (addr_r >= BASE_ADDR) && (offset_s < SPAN);
    assign idx_s      = offset_s[IDX_W+2:3];

    // size, the byte offset and the upper offset bits do not affect the access
    logic unused_s;
    assign unused_s = ^{dreq[74:72], offset_s[63:IDX_W+3], offset_s[2:0]};

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        addr_ok_s = 1'b0;
        data_ok_s = 1'b0;
        rdata_s   = 64'd0;
        oob_s     = 1'b0;
        latch_s   = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid_s) begin
                    state_s   = WAIT;
                    cnt_s     = CNT_INIT;
                    addr_ok_s = 1'b1;
                    latch_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    state_s   = RESP;
                    data_ok_s = 1'b1;
                    oob_s     = ~in_range_s;
                    commit_s  = in_range_s && (strobe_r != 8'd0);
                    if (in_range_s && (strobe_r == 8'd0)) begin
                        rdata_s = mem_r[idx_s];
                    end else begin
                        rdata_s = 64'd0;
                    end
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, latency counter and registered bus outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            addr_ok_r <= 1'b0;
            data_ok_r <= 1'b0;
            rdata_r   <= 64'd0;
            oob_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            addr_ok_r <= addr_ok_s;
            data_ok_r <= data_ok_s;
            rdata_r   <= rdata_s;
            oob_r     <= oob_s;
        end
    end

    // Latch the request on acceptance so later dreq changes are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_r   <= 64'd0;
            strobe_r <= 8'd0;
            wdata_r  <= 64'd0;
        end else if (latch_s) begin
            addr_r   <= req_addr_s;
            strobe_r <= req_strobe_s;
            wdata_r  <= req_data_s;
        end
    end

    // Byte-masked write commit; array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_s] <= (mem_r[idx_s] & ~strobe_mask(strobe_r))
                          | (wdata_r & strobe_mask(strobe_r));
        end
    end

    assign dresp = {addr_ok_r, data_ok_r, rdata_r};
    assign oob   = oob_r;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed testbench for dbus_responder (LATENCY=2, MEM_WORDS=1024).
module tb_dbus_responder;

    localparam int          LAT  = 2;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] LAST = 64'h0000_0000_8000_1FF8;
    localparam logic [63:0] ENDA = 64'h0000_0000_8000_2000;
    localparam logic [63:0] W10  = 64'h0000_0000_8000_0010;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [139:0] dreq = 140'd0;
    logic [65:0]  dresp;
    logic         oob;

    int checks = 0;
    int errors = 0;

    dbus_responder #(.MEM_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .dreq(dreq), .dresp(dresp), .oob(oob)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] data);
        dreq = {1'b1, addr, 3'd3, strobe, data};
    endtask

    // From a driven request in IDLE: accept edge, wait for data_ok, release.
    task automatic finish_txn(output logic [63:0] rd, output logic ob);
        int  n;
        int  stray;
        bit  got;
        tick();
        chk("addr_ok_on_accept", {63'd0, dresp[65]}, 64'd1);
        n = 0; stray = 0; got = 1'b0; rd = 64'hX; ob = 1'bX;
        while (!got && n < 20) begin
            tick();
            n++;
            if (dresp[65]) stray++;
            if (dresp[64]) begin
                got = 1'b1;
                rd  = dresp[63:0];
                ob  = oob;
            end
        end
        chk("data_ok_latency", 64'(n), 64'(LAT));
        chk("addr_ok_single_cycle", 64'(stray), 64'd0);
        dreq[139] = 1'b0;
        tick();
        chk("data_ok_one_cycle", {62'd0, dresp[64], oob}, 64'd0);
    endtask

    task automatic txn(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] data,
                       output logic [63:0] rd, output logic ob);
        drive(addr, strobe, data);
        finish_txn(rd, ob);
    endtask

    initial begin
        logic [63:0] rd;
        logic        ob;
        int          n_aok, n_dok, last_dok, bad_data;

        // 1. reset held with valid high; seed word 0 once reset releases
        #1 resetn = 1'b0;
        drive(BASE, 8'hFF, 64'hDEAD_BEEF_0000_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", {61'd0, dresp[65], dresp[64], oob}, 64'd0);
        end
        chk("reset_data", dresp[63:0], 64'd0);
        resetn = 1'b1;
        finish_txn(rd, ob);
        chk("seed_w0_oob", {63'd0, ob}, 64'd0);

        // 2. full write then read
        txn(W10, 8'hFF, 64'h1122_3344_5566_7788, rd, ob);
        chk("write_resp_data", rd, 64'd0);
        chk("write_oob", {63'd0, ob}, 64'd0);
        txn(W10, 8'h00, 64'd0, rd, ob);
        chk("read_full", rd, 64'h1122_3344_5566_7788);

        // 3. partial write of the low four bytes
        txn(W10, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, rd, ob);
        txn(W10, 8'h00, 64'd0, rd, ob);
        chk("read_partial", rd, 64'h1122_3344_CCCC_DDDD);

        // 4. out-of-range accesses on both sides of the window
        txn(LAST, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, rd, ob);
        txn(64'h0000_0000_7FFF_FFF8, 8'h00, 64'd0, rd, ob);
        chk("oob_low_flag", {63'd0, ob}, 64'd1);
        chk("oob_low_data", rd, 64'd0);
        txn(ENDA, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, ob);
        chk("oob_high_flag", {63'd0, ob}, 64'd1);
        chk("oob_high_data", rd, 64'd0);
        txn(BASE, 8'h00, 64'd0, rd, ob);
        chk("word0_intact", rd, 64'hDEAD_BEEF_0000_0001);
        chk("word0_oob", {63'd0, ob}, 64'd0);
        txn(LAST, 8'h00, 64'd0, rd, ob);
        chk("last_word_intact", rd, 64'h0F0E_0D0C_0B0A_0908);

        // 5. ten back-to-back reads with valid held high, 4 cycles each
        n_aok = 0; n_dok = 0; last_dok = 0; bad_data = 0;
        drive(W10, 8'h00, 64'd0);
        for (int t = 1; t <= 10 * (LAT + 2); t++) begin
            tick();
            if (dresp[65]) n_aok++;
            if (dresp[64]) begin
                n_dok++;
                last_dok = t;
                if (dresp[63:0] !== 64'h1122_3344_CCCC_DDDD) bad_data++;
            end
        end
        dreq[139] = 1'b0;
        chk("b2b_addr_ok_count", 64'(n_aok), 64'd10);
        chk("b2b_data_ok_count", 64'(n_dok), 64'd10);
        chk("b2b_last_data_ok_cycle", 64'(last_dok), 64'd39);
        chk("b2b_read_data", 64'(bad_data), 64'd0);
        tick();
        tick();
        chk("b2b_idle_after", {62'd0, dresp[65], dresp[64]}, 64'd0);

        // 6. reset during WAIT discards the uncommitted write
        drive(W10, 8'hFF, 64'h5555_5555_5555_5555);
        tick();
        chk("abort_accept", {63'd0, dresp[65]}, 64'd1);
        resetn = 1'b0;
        #1;
        chk("abort_async_clear", {61'd0, dresp[65], dresp[64], oob}, 64'd0);
        tick();
        dreq[139] = 1'b0;
        resetn = 1'b1;
        n_dok = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (dresp[64]) n_dok++;
        end
        chk("abort_no_data_ok", 64'(n_dok), 64'd0);
        txn(W10, 8'h00, 64'd0, rd, ob);
        chk("abort_old_value", rd, 64'h1122_3344_CCCC_DDDD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
